// File: rtl/clic_irq_sequencer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clic_pkg : shared types, constants and helpers for the CLIC       |
// | interrupt sequencer.                             rev 1.0          |
// +-------------------------------------------------------------------+
package clic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    CLAIM = 2'd2,
    HOLD  = 2'd3
  } clic_seq_state_e;

  localparam int CLIC_HOLDOFF_CYCLES = 3;

  // Bits below the level field read as 1; nlbits above 8 saturate at 8.
  function automatic logic [7:0] clic_level_mask(input logic [3:0] nlbits);
    if (nlbits >= 4'd8) begin
      return 8'h00;
    end
    return 8'hFF >> nlbits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clic_irq_sequencer_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clic_irq_sequencer_if : core-side interrupt offer handshake and   |
// | edge-clear pulse.                                rev 1.0          |
// +-------------------------------------------------------------------+
interface clic_irq_sequencer_if #(
  parameter int N_SOURCE = 32
);
  localparam int SRC_W = $clog2(N_SOURCE);

  logic                irq_valid_o;
  logic                irq_ready_i;
  logic [SRC_W-1:0]    irq_id_o;
  logic [7:0]          irq_level_o;
  logic                irq_shv_o;
  logic [N_SOURCE-1:0] edge_clr_o;

  modport master (
    output irq_valid_o,
    input  irq_ready_i,
    output irq_id_o,
    output irq_level_o,
    output irq_shv_o,
    output edge_clr_o
  );

  modport slave (
    input  irq_valid_o,
    output irq_ready_i,
    input  irq_id_o,
    input  irq_level_o,
    input  irq_shv_o,
    input  edge_clr_o
  );

endinterface
`default_nettype wire

// File: rtl/clic_irq_sequencer_max_tree.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clic_max_tree : combinational tournament picking the eligible     |
// | source with the largest intctl, higher ID on ties.  rev 1.0       |
// +-------------------------------------------------------------------+
module clic_max_tree #(
  parameter int N_SOURCE = 32,
  localparam int SRC_W   = $clog2(N_SOURCE)
) (
  input  logic [N_SOURCE-1:0] eligible_i,
  input  logic [7:0]          intctl_i [N_SOURCE],
  output logic                win_valid_o,
  output logic [SRC_W-1:0]    win_id_o,
  output logic [7:0]          win_ctl_o
);

  localparam int LEAVES = 1 << SRC_W;
  localparam int NODES  = 2 * LEAVES - 1;

  logic             node_vld [NODES];
  logic [7:0]       node_ctl [NODES];
  logic [SRC_W-1:0] node_id  [NODES];
  logic             take_right;

  // Heap layout: leaves at LEAVES-1.., left child always holds the lower IDs,
  // so preferring the right child on equal intctl gives the higher-ID tie-break.
  always_comb begin
    take_right = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      node_vld[n] = 1'b0;
      node_ctl[n] = 8'h00;
      node_id[n]  = '0;
    end
    for (int i = 0; i < LEAVES; i++) begin
      node_id[LEAVES-1+i] = SRC_W'(i);
      if (i < N_SOURCE) begin
        node_vld[LEAVES-1+i] = eligible_i[i];
        node_ctl[LEAVES-1+i] = eligible_i[i] ? intctl_i[i] : 8'h00;
      end
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      take_right = node_vld[2*k+2] &
                   (~node_vld[2*k+1] | (node_ctl[2*k+2] >= node_ctl[2*k+1]));
      node_vld[k] = node_vld[2*k+1] | node_vld[2*k+2];
      node_ctl[k] = take_right ? node_ctl[2*k+2] : node_ctl[2*k+1];
      node_id[k]  = take_right ? node_id[2*k+2]  : node_id[2*k+1];
    end
  end

  assign win_valid_o = node_vld[0];
  assign win_id_o    = node_id[0];
  assign win_ctl_o   = node_ctl[0];

endmodule
`default_nettype wire

// File: rtl/clic_irq_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | clic_irq_sequencer : arbitrates CLIC sources and offers the       |
// | winner to the core, with edge-clear and re-arbitration holdoff.   |
// | rev 1.0                                                           |
// +-------------------------------------------------------------------+
module clic_irq_sequencer
  import clic_pkg::*;
#(
  parameter int N_SOURCE   = 32,
  parameter int INTCTLBITS = 8,
  localparam int SRC_W     = $clog2(N_SOURCE)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [N_SOURCE-1:0] ip_i,
  input  logic [N_SOURCE-1:0] ie_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] shv_i,
  input  logic [7:0]          intctl_i [N_SOURCE],
  input  logic [7:0]          mintthresh_i,
  input  logic [3:0]          nlbits_i,
  clic_irq_sequencer_if.master irq_if
);

  localparam logic [7:0] UNIMPL_MASK = 8'(8'hFF >> INTCTLBITS);

  logic [7:0]          lvl_mask;
  logic [N_SOURCE-1:0] elig_d;
  logic [7:0]          ctl_d [N_SOURCE];

  logic [N_SOURCE-1:0] elig_q;
  logic [7:0]          ctl_q [N_SOURCE];

  logic                win_valid;
  logic [SRC_W-1:0]    win_id;
  logic [7:0]          win_ctl;

  logic                s2_valid_q;
  logic [SRC_W-1:0]    s2_id_q;
  logic [7:0]          s2_level_q;
  logic                s2_shv_q;

  clic_seq_state_e     state_q;
  logic [1:0]          cnt_q;
  logic                valid_q;
  logic [N_SOURCE-1:0] edge_clr_q;

  assign lvl_mask = clic_level_mask(nlbits_i);

  always_comb begin
    elig_d = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      ctl_d[i]  = intctl_i[i] | UNIMPL_MASK;
      elig_d[i] = enable_i & ip_i[i] & ie_i[i] & ((ctl_d[i] | lvl_mask) > mintthresh_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      elig_q <= '0;
      for (int i = 0; i < N_SOURCE; i++) begin
        ctl_q[i] <= 8'h00;
      end
    end else begin
      elig_q <= elig_d;
      for (int i = 0; i < N_SOURCE; i++) begin
        ctl_q[i] <= ctl_d[i];
      end
    end
  end

  clic_max_tree #(
    .N_SOURCE (N_SOURCE)
  ) u_max_tree (
    .eligible_i  (elig_q),
    .intctl_i    (ctl_q),
    .win_valid_o (win_valid),
    .win_id_o    (win_id),
    .win_ctl_o   (win_ctl)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_level_q <= 8'h00;
      s2_shv_q   <= 1'b0;
    end else begin
      s2_valid_q <= win_valid;
      s2_id_q    <= win_id;
      s2_level_q <= win_ctl | lvl_mask;
      s2_shv_q   <= shv_i[win_id];
    end
  end

  // Handshake takes priority over withdrawal when both land in one OFFER cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      valid_q    <= 1'b0;
      edge_clr_q <= '0;
    end else begin
      edge_clr_q <= '0;
      case (state_q)
        IDLE: begin
          if (s2_valid_q) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
          end
        end
        OFFER: begin
          if (valid_q && irq_if.irq_ready_i) begin
            state_q <= CLAIM;
            valid_q <= 1'b0;
            if (le_i[s2_id_q]) begin
              edge_clr_q <= N_SOURCE'(1) << s2_id_q;
            end
          end else if (!s2_valid_q) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        CLAIM: begin
          state_q <= HOLD;
          cnt_q   <= 2'(CLIC_HOLDOFF_CYCLES);
        end
        HOLD: begin
          if (cnt_q <= 2'd1) begin
            cnt_q   <= 2'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_if.irq_valid_o = valid_q;
  assign irq_if.irq_id_o    = s2_id_q;
  assign irq_if.irq_level_o = s2_level_q;
  assign irq_if.irq_shv_o   = s2_shv_q;
  assign irq_if.edge_clr_o  = edge_clr_q;

endmodule
`default_nettype wire
